// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable interval timer.
//   state_e       : timer FSM state (IDLE, RUN)
//   MODE_ONESHOT  : stop after the first terminal count
//   MODE_PERIODIC : auto-reload and keep running after each terminal count
package timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for timer_prog. Only built when TIMER_PRESCALE_EN is defined.
// The counter advances on every enabled cycle and raises tick on the cycle it
// sits at PRESCALE-1, then wraps to 0.
// Ports:
//   div_clk : timer clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : synchronous clear (start, abort or timer idle); wins over enable
//   enable  : advance the prescaler this cycle
//   tick    : high on the enabled cycle where the prescaler reaches PRESCALE-1
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic div_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/timer_prog.sv
// Programmable interval timer in the divided-clock domain.
// Counts enabled ticks from 0 up to a limit latched at start and emits a one-cycle
// terminado pulse on the terminal count; one-shot or periodic (auto-reload) mode.
// Optional macro TIMER_PRESCALE_EN: adds parameter PRESCALE and divides the enabled
// cycles by PRESCALE before they reach the main counter.
// Ports:
//   div_clk    : timer clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : pulse; latch time_value/periodic and (re)start counting from 0
//   abort      : pulse; stop and return to IDLE (highest priority)
//   contando   : level count enable; 0 freezes the count
//   periodic   : mode sampled with start (1 = auto-reload, 0 = one-shot)
//   time_value : terminal count sampled with start
//   terminado  : registered one-cycle pulse on terminal count
//   busy       : high while in RUN
//   count      : registered current count
module timer_prog
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RESET_MODE = 1
`ifdef TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE   = 4
`endif
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             contando,
  input  logic             periodic,
  input  logic [WIDTH-1:0] time_value,
  output logic             terminado,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic ResetModeVal = (RESET_MODE != 0) ? MODE_PERIODIC : MODE_ONESHOT;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             term_q, term_d;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .div_clk (div_clk),
    .rst     (rst),
    .clear   (abort || start || (state_q == IDLE)),
    .enable  ((state_q == RUN) && contando),
    .tick    (tick)
  );
`else
  assign tick = contando;
`endif

  // Priority: abort, then start, then terminal count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    term_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      limit_d = time_value;
      mode_d  = periodic;
    end else if (state_q == RUN) begin
      if (tick) begin
        if (count_q == limit_q) begin
          count_d = '0;
          term_d  = 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= ResetModeVal;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      term_q  <= term_d;
    end
  end

  assign terminado = term_q;
  assign busy      = (state_q == RUN);
  assign count     = count_q;

endmodule

// File: tb/tb_timer_prog.sv
module tb_timer_prog;

`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       div_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       contando = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] time_value = 8'h00;
  logic       terminado;
  logic       busy;
  logic [7:0] count;

  timer_prog #(
    .WIDTH      (8),
    .RESET_MODE (1)
`ifdef TIMER_PRESCALE_EN
    ,
    .PRESCALE   (P)
`endif
  ) dut (
    .div_clk    (div_clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .contando   (contando),
    .periodic   (periodic),
    .time_value (time_value),
    .terminado  (terminado),
    .busy       (busy),
    .count      (count)
  );

  always #5 div_clk = ~div_clk;

  typedef struct packed {
    logic       term;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   step = 0;

  // Reference: timing derived from enabled cycles since the last start.
  bit m_run = 1'b0;
  bit m_per = 1'b0;
  int m_l = 0;
  int m_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and push the expected registered outputs.
  task automatic drive(input logic st, input logic ab, input logic en, input logic per,
                       input logic [7:0] tv);
    exp_t e;
    int   k;
    @(negedge div_clk);
    start = st;
    abort = ab;
    contando = en;
    periodic = per;
    time_value = tv;
    e.term = 1'b0;
    if (ab) begin
      m_run = 1'b0;
      e.cnt = 8'd0;
    end else if (st) begin
      m_run = 1'b1;
      m_per = per;
      m_l = int'(tv);
      m_n = 0;
      e.cnt = 8'd0;
    end else if (m_run) begin
      if (en) m_n++;
      k = m_n / P;
      e.cnt = 8'(k % (m_l + 1));
      e.term = en && (m_n % P == 0) && (k % (m_l + 1) == 0);
      if (e.term && !m_per) m_run = 1'b0;
    end else begin
      e.cnt = 8'd0;
    end
    e.busy = m_run;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, en, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  always @(posedge div_clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      step++;
      chk($sformatf("c%0d_term", step), {31'd0, terminado}, {31'd0, mon_e.term});
      chk($sformatf("c%0d_busy", step), {31'd0, busy}, {31'd0, mon_e.busy});
      chk($sformatf("c%0d_count", step), {24'd0, count}, {24'd0, mon_e.cnt});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #3 rst = 1'b1;
    #1;
    chk("rst_term", {31'd0, terminado}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    @(negedge div_clk);
    @(negedge div_clk);
    rst = 1'b0;

    // No start: enable alone must not count.
    run(20, 1'b1);

    // Periodic, limit 3.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd3);
    run(13 * P, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

    // One-shot, limit 5; stays idle afterwards.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    run(9 * P, 1'b1);

    // Periodic limit 4 with enable dropped for 3 cycles at count 2.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    run(2 * P, 1'b1);
    run(3, 1'b0);
    run(7 * P, 1'b1);

    // start and abort together at count 2.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    run(2 * P, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd7);
    run(3, 1'b1);

    // start on a terminal cycle restarts with the new limit.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    run(3 * P - 1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    run(5 * P, 1'b1);

    // Limit 0: periodic fires every tick; one-shot fires once.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
    run(4 * P, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    run(3 * P, 1'b1);

    // Full-range limit.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd255);
    run(258 * P, 1'b1);

    // Abort mid-period then restart gives a full period.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    run(P + 1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    run(10 * P, 1'b1);

    // Async reset in the middle of a count.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd9);
    run(3, 1'b1);
    @(negedge div_clk);
    contando = 1'b0;
    start = 1'b0;
    #2 rst = 1'b1;
    m_run = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_count", {24'd0, count}, 32'd0);
    chk("midrst_term", {31'd0, terminado}, 32'd0);
    @(negedge div_clk);
    rst = 1'b0;
    run(5, 1'b1);

    @(negedge div_clk);
    @(negedge div_clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_prog.md
Name: timer_prog

Overview:
Parametrised programmable interval timer, successor to the fixed 4-bit tick counter in the slow-clock domain.
- Counts enabled ticks of div_clk up to a programmable limit and emits a one-cycle terminal pulse (terminado).
- Adds over the 4-bit counter: generic width, start/abort control, one-shot vs periodic mode, limit latched at start, visible count and busy status.
- Sits under the divided-clock domain and feeds sequencing FSMs that need timed waits.

Parameters:
WIDTH, 8, width of count and limit.
RESET_MODE, 1, mode after reset: 0 = one-shot, 1 = periodic.

Ports:
div_clk  in  1  timer clock (divided clock), rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; latch limit and (re)start counting from 0.
abort  in  1  single-cycle pulse; stop, return to IDLE.
contando  in  1  level count-enable; 0 freezes the count.
periodic  in  1  mode, sampled with start: 1 = auto-reload, 0 = one-shot.
time_value  in  WIDTH  terminal count, sampled with start.
terminado  out  1  one-cycle pulse on terminal count.
busy  out  1  high in RUN state.
count  out  WIDTH  current counter value.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, terminado=0, busy=0, limit=0, mode=RESET_MODE.
- States are IDLE and RUN. All outputs are registered, so changes appear one cycle after the causing edge.
- IDLE:
  - count held at 0.
  - start=1 -> limit<=time_value, mode<=periodic, count<=0, go to RUN.
- RUN, contando=1:
  - count!=limit -> count<=count+1, terminado<=0.
  - count==limit -> count<=0, terminado<=1.
    - Periodic mode: stay in RUN.
    - One-shot mode: go to IDLE.
  - Period is limit+1 enabled cycles.
- RUN, contando=0: count frozen, terminado<=0, state unchanged.
- terminado is never high for two consecutive cycles unless limit=0 and contando is held high in periodic mode. In that case it is high every enabled cycle.
- limit=0: terminal on the first enabled cycle after start.
- Changes to time_value/periodic during RUN are ignored until the next start.
- Priority when inputs coincide, highest first: abort, then start, then terminal count.
  - abort in any state -> IDLE, count<=0, terminado<=0.
  - start while in RUN -> restart: relatch limit and mode, count<=0, terminado<=0, even on a terminal cycle.
- start and abort in IDLE with contando=0 still take effect; contando gates counting only.
- Arithmetic is unsigned, WIDTH bits. count never exceeds limit, so no wrap past 2^WIDTH-1 occurs. limit=2^WIDTH-1 is legal.
- Reset asserted mid-count clears immediately (async). After release the timer waits in IDLE for start.
- busy=1 exactly while state=RUN.

Optional Feature:
TIMER_PRESCALE_EN
- Defined:
  - Adds parameter PRESCALE (default 4, >=1).
  - A free-running prescale counter advances only when state=RUN and contando=1.
  - The main count advances, or the terminal fires, only on the cycle the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - Period = (limit+1)*PRESCALE enabled cycles.
  - The prescaler clears on reset, start, abort and in IDLE.
- Not defined: every enabled cycle is a tick, with the behaviour exactly as above.

Decomposition:
- Package timer_pkg holds:
  - state typedef (IDLE, RUN).
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module timer_prescaler holds the prescale counter and tick output. It is instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- WIDTH=8, rst pulse -> terminado=0, busy=0, count=0; with no start, contando=1 for 20 cycles leaves count at 0.
- start with time_value=3, periodic=1, contando=1 -> count 0,1,2,3,0,...; terminado high on cycles 4, 8, 12 after start; busy stays 1.
- start with time_value=5, periodic=0 -> single terminado 6 enabled cycles after start; busy drops the same cycle; count stays 0 thereafter.
- time_value=4 periodic, drop contando for 3 cycles at count=2 -> count holds at 2, terminado delayed 3 cycles.
- start and abort in the same cycle at count=2 -> IDLE, count=0, no terminado. start alone on a terminal cycle -> terminado=0, count=0, relatched limit used.
- TIMER_PRESCALE_EN with PRESCALE=4, time_value=1 periodic -> terminado every 8 enabled cycles; abort mid-prescale -> restart gives a full 8-cycle period.
